// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and angle-fold helper for the CORDIC vectoring post-processor.
package cordic_pkg;

  localparam int MAG_WIDTH = 16;
  localparam int ANG_WIDTH = 16;

  localparam logic [15:0]        K_INV_Q16  = 16'd39797;
  localparam logic signed [15:0] PI_Q13     = 16'sd25736;
  localparam int                 ATAN_SCALE = 16384;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // Q2.14 -> Q3.13 by flooring shift, then undo the half-plane pre-rotation by adding or removing pi.
  function automatic logic signed [15:0] foldAngle(input logic signed [15:0] z, input logic flip);
    logic signed [15:0] a;
    a = z >>> 1;
    if (!flip)
      return a;
    else if (a <= 16'sd0)
      return a + PI_Q13;
    else
      return a - PI_Q13;
  endfunction

endpackage

// File: rtl/cordic_vec_post_seq_mul.sv
// 16-cycle shift-add unsigned multiplier: one multiplier bit per clock, LSB first.
module seq_mul_u16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product
);

  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] w_addend;

  assign w_addend = {16'b0, r_a} << r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_b[r_cnt])
        r_acc <= r_acc + w_addend;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15)
        r_busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge adds the final partial product.
  assign o_done    = r_busy && (r_cnt == 4'd15);
  assign o_busy    = r_busy;
  assign o_product = r_acc;

endmodule

// File: rtl/cordic_vec_post.sv
// CORDIC vectoring post-stage: removes the CORDIC gain from X and folds Z back into (-pi, pi].
module cordic_vec_post
  import cordic_pkg::*;
#(
  parameter int          MAG_W = 16,
  parameter int          ANG_W = 16,
  parameter logic [15:0] K_INV = K_INV_Q16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] x_in,
  input  logic [ANG_W-1:0] z_in,
  input  logic             flip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] mag_out,
  output logic [ANG_W-1:0] angle_out
);

  state_t             r_state;
  state_t             w_nextState;
  logic signed [15:0] r_angle;
  logic               w_accept;
  logic               w_mulBusy;
  logic               w_mulDone;
  logic [31:0]        w_product;

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  seq_mul_u16 u_mul (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_start   (w_accept),
    .i_a       (x_in),
    .i_b       (K_INV),
    .o_busy    (w_mulBusy),
    .o_done    (w_mulDone),
    .o_product (w_product)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // A multiplier that stops without signalling done returns the FSM to IDLE instead of hanging in MUL.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = MUL;
      MUL: begin
        if (w_mulDone)
          w_nextState = DONE;
        else if (!w_mulBusy)
          w_nextState = IDLE;
      end
      DONE: if (out_ready) w_nextState = w_accept ? MUL : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_angle <= '0;
    else if (w_accept)
      r_angle <= foldAngle(z_in, flip);
  end

  assign out_valid = (r_state == DONE);
  // Half-up rounding of the Q16.16 product back to an integer magnitude; the sum cannot exceed 32 bits.
  assign mag_out   = MAG_W'((w_product + 32'd32768) >> 16);
  assign angle_out = ANG_W'(r_angle);

endmodule
